// File: rtl/ysyx_23060191_wbu_pkg.sv
// Shared write-back definitions: GPR geometry, scoreboard width and the
// round-robin selector type used by the commit arbiter.
package ysyx_23060191_wbu_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int SB_CNT_W   = 2;

  // Which channel wins the next cycle where both slots hold a result.
  typedef enum logic {
    RR_LSU = 1'b0,
    RR_EXU = 1'b1
  } rrSel_e;

endpackage

// File: rtl/ysyx_23060191_wbu_slot.sv
// One-entry holding slot for a result channel. A result sits here until the
// commit arbiter grants it; a granted slot can be refilled on the same edge,
// so a channel that keeps winning streams one result per cycle.
module ysyx_23060191_WB_SLOT
  import ysyx_23060191_wbu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  wen_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  grant_i,
  output logic                  ready_o,
  output logic                  full_o,
  output logic                  wen_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0]     data_o
);

  logic                  full_q, full_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  fire;

  // Accept when empty or being drained this cycle; a new result has priority
  // over emptying so a granted slot refills without a bubble.
  always_comb begin
    ready_o = rst_n & (~full_q | grant_i);
    fire    = valid_i & ready_o;
    full_d  = full_q;
    wen_d   = wen_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (fire) begin
      full_d = 1'b1;
      wen_d  = wen_i;
      rd_d   = rd_i;
      data_d = data_i;
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  // Slot storage; reset discards whatever result was being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      wen_q  <= wen_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign wen_o  = wen_q;
  assign rd_o   = rd_q;
  assign data_o = data_q;

endmodule

// File: rtl/ysyx_23060191_wbu.sv
// Write-back unit: buffers EXU and LSU results, commits at most one per
// cycle to the GPR write port, counts retirements and keeps a per-register
// pending-write scoreboard for the issue stage.
module ysyx_23060191_wbu
  import ysyx_23060191_wbu_pkg::*;
#(
  parameter int CPU_WIDTH = ysyx_23060191_wbu_pkg::CPU_WIDTH,
  parameter int SB_CNT_W  = ysyx_23060191_wbu_pkg::SB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_exu_valid,
  output logic                  o_exu_ready,
  input  logic                  i_exu_wen,
  input  logic [4:0]            i_exu_rd,
  input  logic [CPU_WIDTH-1:0]  i_exu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic                  i_lsu_wen,
  input  logic [4:0]            i_lsu_rd,
  input  logic [CPU_WIDTH-1:0]  i_lsu_data,
  input  logic                  i_issue_valid,
  input  logic [4:0]            i_issue_rd,
  output logic                  o_issue_ready,
  output logic [31:0]           o_busy,
  output logic                  o_wr_en_Rd,
  output logic [4:0]            o_addr_Rd,
  output logic [CPU_WIDTH-1:0]  o_data_Rd,
  output logic                  o_retire_valid,
  output logic [31:0]           o_retire_cnt
);

  logic                 exuFull, exuWen, lsuFull, lsuWen;
  logic [4:0]           exuRd, lsuRd;
  logic [CPU_WIDTH-1:0] exuData, lsuData;
  logic                 exuGrant, lsuGrant, anyGrant;

  rrSel_e               rrPtr_q, rrPtr_d;
  logic [31:0]          retireCnt_q, retireCnt_d;
  logic [SB_CNT_W-1:0]  sbCnt_q [REG_NUM];
  logic [SB_CNT_W-1:0]  sbCnt_d [REG_NUM];
  logic                 commitHit, issueFire;

  ysyx_23060191_WB_SLOT #(.DATA_W(CPU_WIDTH)) uExuSlot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (i_exu_valid),
    .wen_i   (i_exu_wen),
    .rd_i    (i_exu_rd),
    .data_i  (i_exu_data),
    .grant_i (exuGrant),
    .ready_o (o_exu_ready),
    .full_o  (exuFull),
    .wen_o   (exuWen),
    .rd_o    (exuRd),
    .data_o  (exuData)
  );

  ysyx_23060191_WB_SLOT #(.DATA_W(CPU_WIDTH)) uLsuSlot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (i_lsu_valid),
    .wen_i   (i_lsu_wen),
    .rd_i    (i_lsu_rd),
    .data_i  (i_lsu_data),
    .grant_i (lsuGrant),
    .ready_o (o_lsu_ready),
    .full_o  (lsuFull),
    .wen_o   (lsuWen),
    .rd_o    (lsuRd),
    .data_o  (lsuData)
  );

  // Round-robin pointer register; starts favouring LSU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rrPtr_q <= RR_LSU;
    else        rrPtr_q <= rrPtr_d;
  end

  // The pointer only flips after a contested cycle, handing priority to the loser.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (exuFull && lsuFull) rrPtr_d = (rrPtr_q == RR_LSU) ? RR_EXU : RR_LSU;
  end

  // Grant a lone full slot outright, otherwise follow the pointer; drive the
  // GPR port from the granted slot, suppressing writes to x0.
  always_comb begin
    exuGrant       = exuFull & (~lsuFull | (rrPtr_q == RR_EXU));
    lsuGrant       = lsuFull & (~exuFull | (rrPtr_q == RR_LSU));
    anyGrant       = exuGrant | lsuGrant;
    o_wr_en_Rd     = 1'b0;
    o_addr_Rd      = '0;
    o_data_Rd      = '0;
    if (exuGrant) begin
      o_wr_en_Rd = exuWen & (exuRd != 5'd0);
      o_addr_Rd  = exuRd;
      o_data_Rd  = exuData;
    end else if (lsuGrant) begin
      o_wr_en_Rd = lsuWen & (lsuRd != 5'd0);
      o_addr_Rd  = lsuRd;
      o_data_Rd  = lsuData;
    end
    o_retire_valid = anyGrant;
  end

  // Retirement counter advances once per commit, including non-writing ones.
  always_comb begin
    retireCnt_d = anyGrant ? retireCnt_q + 32'd1 : retireCnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retireCnt_q <= '0;
    else        retireCnt_q <= retireCnt_d;
  end

  assign o_retire_cnt = retireCnt_q;

  // Issue stalls only when the target counter is saturated and no commit to
  // that register frees a slot this cycle; x0 never stalls.
  always_comb begin
    commitHit     = o_wr_en_Rd & (o_addr_Rd == i_issue_rd);
    o_issue_ready = rst_n & ((i_issue_rd == 5'd0) |
                             (sbCnt_q[i_issue_rd] != {SB_CNT_W{1'b1}}) |
                             commitHit);
    issueFire     = i_issue_valid & o_issue_ready & (i_issue_rd != 5'd0);
  end

  // Per-register pending count: issue adds, writing commit removes, both
  // together cancel, and an empty counter never wraps below zero.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      sbCnt_d[r] = sbCnt_q[r];
      if (r != 0) begin
        if (issueFire && (i_issue_rd == 5'(r)) &&
            !(o_wr_en_Rd && (o_addr_Rd == 5'(r)))) begin
          sbCnt_d[r] = sbCnt_q[r] + SB_CNT_W'(1);
        end else if (o_wr_en_Rd && (o_addr_Rd == 5'(r)) &&
                     !(issueFire && (i_issue_rd == 5'(r))) &&
                     (sbCnt_q[r] != '0)) begin
          sbCnt_d[r] = sbCnt_q[r] - SB_CNT_W'(1);
        end
      end else begin
        sbCnt_d[r] = '0;
      end
    end
  end

  // Scoreboard counters; all cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) sbCnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) sbCnt_q[r] <= sbCnt_d[r];
    end
  end

  // Busy reflects registered counts only, so a same-cycle issue shows next cycle.
  always_comb begin
    o_busy = '0;
    for (int r = 1; r < REG_NUM; r++) o_busy[r] = (sbCnt_q[r] != '0);
  end

endmodule

// File: tb/tb_ysyx_23060191_wbu.sv
// Self-checking bench for the write-back unit: a directed vector table,
// hand-written scoreboard/reset/wrap sequences, and a randomized run checked
// against a transaction-level model of slots, arbitration and counters.
`timescale 1ns/1ps
module tb_ysyx_23060191_wbu;

   logic        clk;
   logic        rst_n;
   logic        i_exu_valid, i_exu_wen;
   logic [4:0]  i_exu_rd;
   logic [31:0] i_exu_data;
   logic        i_lsu_valid, i_lsu_wen;
   logic [4:0]  i_lsu_rd;
   logic [31:0] i_lsu_data;
   logic        i_issue_valid;
   logic [4:0]  i_issue_rd;
   logic        o_exu_ready, o_lsu_ready, o_issue_ready;
   logic [31:0] o_busy;
   logic        o_wr_en_Rd;
   logic [4:0]  o_addr_Rd;
   logic [31:0] o_data_Rd;
   logic        o_retire_valid;
   logic [31:0] o_retire_cnt;

   int checksTotal;
   int checksPassed;

   ysyx_23060191_wbu dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_exu_valid    (i_exu_valid),
      .o_exu_ready    (o_exu_ready),
      .i_exu_wen      (i_exu_wen),
      .i_exu_rd       (i_exu_rd),
      .i_exu_data     (i_exu_data),
      .i_lsu_valid    (i_lsu_valid),
      .o_lsu_ready    (o_lsu_ready),
      .i_lsu_wen      (i_lsu_wen),
      .i_lsu_rd       (i_lsu_rd),
      .i_lsu_data     (i_lsu_data),
      .i_issue_valid  (i_issue_valid),
      .i_issue_rd     (i_issue_rd),
      .o_issue_ready  (o_issue_ready),
      .o_busy         (o_busy),
      .o_wr_en_Rd     (o_wr_en_Rd),
      .o_addr_Rd      (o_addr_Rd),
      .o_data_Rd      (o_data_Rd),
      .o_retire_valid (o_retire_valid),
      .o_retire_cnt   (o_retire_cnt)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ev, ew;
      logic [4:0]  er;
      logic [31:0] ed;
      logic        lv, lw;
      logic [4:0]  lr;
      logic [31:0] ld;
      logic        xWen;
      logic [4:0]  xAddr;
      logic [31:0] xData;
      logic        xRv;
      logic [31:0] xRc;
      logic        xEr, xLr;
   } vec_t;

   vec_t vecs [14];

   // Reference model state: slot contents, who is favoured next, pending counts
   bit          mEF, mEW, mLF, mLW, mPreferLsu;
   int          mER, mLR;
   logic [31:0] mED, mLD, mRetire;
   int          mCnt [32];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checksTotal++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic ev, input logic ew, input logic [4:0] er, input logic [31:0] ed,
                                input logic lv, input logic lw, input logic [4:0] lr, input logic [31:0] ld,
                                input logic iv, input logic [4:0] ir);
      i_exu_valid   = ev;
      i_exu_wen     = ew;
      i_exu_rd      = er;
      i_exu_data    = ed;
      i_lsu_valid   = lv;
      i_lsu_wen     = lw;
      i_lsu_rd      = lr;
      i_lsu_data    = ld;
      i_issue_valid = iv;
      i_issue_rd    = ir;
   endtask

   task automatic idleInputs();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic modelReset();
      mEF = 0; mEW = 0; mER = 0; mED = 0;
      mLF = 0; mLW = 0; mLR = 0; mLD = 0;
      mPreferLsu = 1;
      mRetire = 0;
      for (int r = 0; r < 32; r++) mCnt[r] = 0;
   endtask

   // Hold reset over two edges, check the reset state, release at a negedge
   task automatic doReset();
      idleInputs();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_exu_ready", {31'd0, o_exu_ready}, 32'd0);
      checkOutput("rst_lsu_ready", {31'd0, o_lsu_ready}, 32'd0);
      checkOutput("rst_issue_ready", {31'd0, o_issue_ready}, 32'd0);
      checkOutput("rst_wr_en", {31'd0, o_wr_en_Rd}, 32'd0);
      checkOutput("rst_busy", o_busy, 32'd0);
      checkOutput("rst_retire_cnt", o_retire_cnt, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   // One cycle against the model: predict, compare, then advance the model
   task automatic modelCycle();
      bit          gE, gL, g, sw, expWrEn, expEr, expLr, expIr, contested;
      int          sr, commitRd, issueRd, ir;
      logic [31:0] sd, expBusy;
      gE = mEF && (!mLF || !mPreferLsu);
      gL = mLF && (!mEF || mPreferLsu);
      g  = gE || gL;
      sw = gE ? mEW : mLW;
      sr = gE ? mER : (gL ? mLR : 0);
      sd = gE ? mED : (gL ? mLD : 32'd0);
      expWrEn  = g && sw && (sr != 0);
      commitRd = expWrEn ? sr : 0;
      expEr = !mEF || gE;
      expLr = !mLF || gL;
      ir = int'(i_issue_rd);
      expIr = (ir == 0) || (mCnt[ir] < 3) || (commitRd == ir);
      expBusy = 0;
      for (int r = 1; r < 32; r++) expBusy[r] = (mCnt[r] != 0);
      checkOutput("rnd_wr_en", {31'd0, o_wr_en_Rd}, {31'd0, expWrEn});
      checkOutput("rnd_addr", {27'd0, o_addr_Rd}, sr);
      checkOutput("rnd_data", o_data_Rd, sd);
      checkOutput("rnd_retire_valid", {31'd0, o_retire_valid}, {31'd0, g});
      checkOutput("rnd_retire_cnt", o_retire_cnt, mRetire);
      checkOutput("rnd_exu_ready", {31'd0, o_exu_ready}, {31'd0, expEr});
      checkOutput("rnd_lsu_ready", {31'd0, o_lsu_ready}, {31'd0, expLr});
      checkOutput("rnd_issue_ready", {31'd0, o_issue_ready}, {31'd0, expIr});
      checkOutput("rnd_busy", o_busy, expBusy);
      contested = mEF && mLF;
      if (i_exu_valid && expEr) begin
         mEF = 1; mEW = i_exu_wen; mER = int'(i_exu_rd); mED = i_exu_data;
      end else if (gE) mEF = 0;
      if (i_lsu_valid && expLr) begin
         mLF = 1; mLW = i_lsu_wen; mLR = int'(i_lsu_rd); mLD = i_lsu_data;
      end else if (gL) mLF = 0;
      if (contested) mPreferLsu = gE;
      if (g) mRetire = mRetire + 32'd1;
      issueRd = (i_issue_valid && expIr && ir != 0) ? ir : 0;
      if (!(issueRd != 0 && issueRd == commitRd)) begin
         if (issueRd != 0) mCnt[issueRd]++;
         if (commitRd != 0 && mCnt[commitRd] > 0) mCnt[commitRd]--;
      end
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      rst_n = 1'b0;
      idleInputs();

      // ev ew er ed | lv lw lr ld | expected wen addr data | retire valid/cnt | readies
      vecs[0]  = '{1, 1, 5, 32'h1234_5678, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 1};
      vecs[1]  = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 5, 32'h1234_5678, 1, 0, 1, 1};
      vecs[2]  = '{1, 1, 1, 32'h11,        1, 1, 2, 32'h22,        0, 0, 32'h0,         0, 1, 1, 1};
      vecs[3]  = '{1, 1, 1, 32'h33,        1, 1, 2, 32'h44,        1, 2, 32'h22,        1, 1, 0, 1};
      vecs[4]  = '{1, 1, 1, 32'h33,        1, 1, 2, 32'h66,        1, 1, 32'h11,        1, 2, 1, 0};
      vecs[5]  = '{1, 1, 1, 32'h55,        1, 1, 2, 32'h66,        1, 2, 32'h44,        1, 3, 0, 1};
      vecs[6]  = '{1, 1, 1, 32'h55,        0, 0, 0, 32'h0,         1, 1, 32'h33,        1, 4, 1, 0};
      vecs[7]  = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 2, 32'h66,        1, 5, 0, 1};
      vecs[8]  = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 1, 32'h55,        1, 6, 1, 1};
      vecs[9]  = '{0, 0, 0, 32'h0,         1, 1, 0, 32'hFFFF_FFFF, 0, 0, 32'h0,         0, 7, 1, 1};
      vecs[10] = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF, 1, 7, 1, 1};
      vecs[11] = '{1, 0, 3, 32'hAB,        0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 8, 1, 1};
      vecs[12] = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 3, 32'hAB,        1, 8, 1, 1};
      vecs[13] = '{0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 9, 1, 1};

      $display("[TB] directed vector table");
      doReset();
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].ev, vecs[i].ew, vecs[i].er, vecs[i].ed,
                       vecs[i].lv, vecs[i].lw, vecs[i].lr, vecs[i].ld, 0, 0);
         #1;
         checkOutput($sformatf("vec%0d_wr_en", i), {31'd0, o_wr_en_Rd}, {31'd0, vecs[i].xWen});
         checkOutput($sformatf("vec%0d_addr", i), {27'd0, o_addr_Rd}, {27'd0, vecs[i].xAddr});
         checkOutput($sformatf("vec%0d_data", i), o_data_Rd, vecs[i].xData);
         checkOutput($sformatf("vec%0d_retire_valid", i), {31'd0, o_retire_valid}, {31'd0, vecs[i].xRv});
         checkOutput($sformatf("vec%0d_retire_cnt", i), o_retire_cnt, vecs[i].xRc);
         checkOutput($sformatf("vec%0d_exu_ready", i), {31'd0, o_exu_ready}, {31'd0, vecs[i].xEr});
         checkOutput($sformatf("vec%0d_lsu_ready", i), {31'd0, o_lsu_ready}, {31'd0, vecs[i].xLr});
         checkOutput($sformatf("vec%0d_busy", i), o_busy, 32'd0);
         @(negedge clk);
      end

      $display("[TB] scoreboard saturation on x7");
      doReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
         #1;
         checkOutput($sformatf("sb7_issue%0d_ready", k), {31'd0, o_issue_ready}, 32'd1);
         @(negedge clk);
      end
      applyStimulus(1, 1, 7, 32'h70, 0, 0, 0, 0, 0, 7);
      #1;
      checkOutput("sb7_busy_set", {31'd0, o_busy[7]}, 32'd1);
      checkOutput("sb7_full_stall", {31'd0, o_issue_ready}, 32'd0);
      @(negedge clk);
      applyStimulus(1, 1, 7, 32'h71, 0, 0, 0, 0, 0, 7);
      #1;
      checkOutput("sb7_commit1_wr", {31'd0, o_wr_en_Rd}, 32'd1);
      checkOutput("sb7_commit_bypass_ready", {31'd0, o_issue_ready}, 32'd1);
      @(negedge clk);
      applyStimulus(1, 1, 7, 32'h72, 0, 0, 0, 0, 0, 7);
      #1;
      checkOutput("sb7_after1_ready", {31'd0, o_issue_ready}, 32'd1);
      checkOutput("sb7_after1_busy", {31'd0, o_busy[7]}, 32'd1);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("sb7_after2_busy", {31'd0, o_busy[7]}, 32'd1);
      checkOutput("sb7_commit3_wr", {31'd0, o_wr_en_Rd}, 32'd1);
      @(negedge clk);
      #1;
      checkOutput("sb7_after3_busy", o_busy, 32'd0);
      @(negedge clk);

      $display("[TB] simultaneous issue and commit on x9, then underflow on x10");
      applyStimulus(1, 1, 9, 32'h90, 0, 0, 0, 0, 1, 9);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
      #1;
      checkOutput("sb9_commit_wr", {31'd0, o_wr_en_Rd}, 32'd1);
      checkOutput("sb9_same_cycle_ready", {31'd0, o_issue_ready}, 32'd1);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("sb9_busy_kept", {31'd0, o_busy[9]}, 32'd1);
      applyStimulus(1, 1, 9, 32'h91, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      idleInputs();
      @(negedge clk);
      #1;
      checkOutput("sb9_single_left", o_busy, 32'd0);
      applyStimulus(1, 1, 10, 32'hA0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      idleInputs();
      @(negedge clk);
      #1;
      checkOutput("sb10_no_underflow", o_busy, 32'd0);
      @(negedge clk);

      $display("[TB] reset during a pending commit");
      applyStimulus(1, 1, 12, 32'hC0DE, 0, 0, 0, 0, 1, 12);
      @(negedge clk);
      idleInputs();
      #1;
      checkOutput("rstmid_pending_wr", {31'd0, o_wr_en_Rd}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid_wr_en", {31'd0, o_wr_en_Rd}, 32'd0);
      checkOutput("rstmid_addr", {27'd0, o_addr_Rd}, 32'd0);
      checkOutput("rstmid_data", o_data_Rd, 32'd0);
      checkOutput("rstmid_retire_valid", {31'd0, o_retire_valid}, 32'd0);
      checkOutput("rstmid_busy", o_busy, 32'd0);
      checkOutput("rstmid_retire_cnt", o_retire_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput($sformatf("rstmid_post%0d_wr", k), {31'd0, o_wr_en_Rd}, 32'd0);
         checkOutput($sformatf("rstmid_post%0d_rv", k), {31'd0, o_retire_valid}, 32'd0);
         @(negedge clk);
      end

      $display("[TB] retire counter wrap");
      force dut.retireCnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retireCnt_q;
      #1;
      checkOutput("wrap_preload", o_retire_cnt, 32'hFFFF_FFFF);
      applyStimulus(1, 1, 4, 32'h4, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      idleInputs();
      @(negedge clk);
      #1;
      checkOutput("wrap_to_zero", o_retire_cnt, 32'd0);
      @(negedge clk);

      $display("[TB] randomized run against reference model");
      doReset();
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(0, 1), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                       $urandom_range(0, 1), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                       $urandom_range(0, 1), 5'($urandom_range(0, 7)));
         #1;
         modelCycle();
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
